// File: rtl/video_pixel_pkg.sv
// Shared pixel-format field layout for the RGB565 <-> XRGB8888 conversion blocks.
package video_pixel_pkg;

    // RGB565 field positions within a 16-bit pixel
    localparam int RGB565_R_LSB = 11;
    localparam int RGB565_R_W   = 5;
    localparam int RGB565_G_LSB = 5;
    localparam int RGB565_G_W   = 6;
    localparam int RGB565_B_LSB = 0;
    localparam int RGB565_B_W   = 5;
    localparam int RGB565_W     = 16;

    // XRGB8888 field positions within a 32-bit pixel; X byte is always zero
    localparam int XRGB_X_LSB = 24;
    localparam int XRGB_R_LSB = 16;
    localparam int XRGB_G_LSB = 8;
    localparam int XRGB_B_LSB = 0;
    localparam int XRGB_CH_W  = 8;
    localparam int XRGB_W     = 32;

endpackage

// File: rtl/rgb565_expand.sv
// Purely combinational RGB565 -> XRGB8888 expansion of one pixel.
// Each channel is widened by replicating its top bits into the new LSBs,
// so full-scale inputs map to 0xFF and zero stays zero.
module rgb565_expand
    import video_pixel_pkg::*;
(
    input  logic [RGB565_W-1:0] pixel,
    output logic [XRGB_W-1:0]   xrgb
);

    logic [RGB565_R_W-1:0] r5;
    logic [RGB565_G_W-1:0] g6;
    logic [RGB565_B_W-1:0] b5;

    assign r5 = pixel[RGB565_R_LSB +: RGB565_R_W];
    assign g6 = pixel[RGB565_G_LSB +: RGB565_G_W];
    assign b5 = pixel[RGB565_B_LSB +: RGB565_B_W];

    // Assemble the widened channels; the X byte stays zero
    always_comb begin
        xrgb = '0;
        xrgb[XRGB_R_LSB +: XRGB_CH_W] = {r5, r5[4:2]};
        xrgb[XRGB_G_LSB +: XRGB_CH_W] = {g6, g6[5:4]};
        xrgb[XRGB_B_LSB +: XRGB_CH_W] = {b5, b5[4:2]};
    end

endmodule

// File: rtl/rgb16to32.sv
// Stream converter: one 64-bit beat of four RGB565 pixels in, up to two
// 64-bit beats of two XRGB8888 pixels each out. The held source beat lives
// in a register and all dst outputs are decoded from registered state only.
// Only DATA_WIDTH = 64 is meaningful.
module rgb16to32
    import video_pixel_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = 1
) (
    input  logic                    aclk,
    input  logic                    aresetn,

    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [DATA_WIDTH-1:0]   src_t_data,
    input  logic [DATA_WIDTH/8-1:0] src_t_strb,
    input  logic [DATA_WIDTH/8-1:0] src_t_keep,
    input  logic                    src_t_last,
    input  logic [DEST_WIDTH-1:0]   src_t_dest,
    input  logic [ID_WIDTH-1:0]     src_t_id,
    input  logic [USER_WIDTH-1:0]   src_t_user,

    output logic                    dst_t_valid,
    input  logic                    dst_t_ready,
    output logic [DATA_WIDTH-1:0]   dst_t_data,
    output logic [DATA_WIDTH/8-1:0] dst_t_strb,
    output logic [DATA_WIDTH/8-1:0] dst_t_keep,
    output logic                    dst_t_last,
    output logic [DEST_WIDTH-1:0]   dst_t_dest,
    output logic [ID_WIDTH-1:0]     dst_t_id,
    output logic [USER_WIDTH-1:0]   dst_t_user
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        LO    = 2'd1,
        HI    = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    last_reg, last_next;
    logic                    upper_reg, upper_next;
    logic                    ready_int;

    logic [XRGB_W-1:0]       half;
    logic [1:0][XRGB_W-1:0]  px;

    // Sideband fields that carry no information for this conversion
    logic unused_inputs;
    assign unused_inputs = ^{src_t_strb, src_t_keep[3:0], src_t_dest, src_t_id, src_t_user};

    // State and held-beat registers; reset discards any beat in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg <= EMPTY;
            data_reg  <= '0;
            last_reg  <= 1'b0;
            upper_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
            upper_reg <= upper_next;
        end
    end

    // Next-state logic; the last output beat of a source beat may overlap
    // with accepting the next source beat so the stream never bubbles
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        last_next  = last_reg;
        upper_next = upper_reg;
        ready_int  = 1'b0;
        case (state_reg)
            EMPTY: ready_int = 1'b1;
            LO:    ready_int = dst_t_ready && !upper_reg;
            HI:    ready_int = dst_t_ready;
            default: ready_int = 1'b0;
        endcase

        case (state_reg)
            EMPTY: begin
                if (src_t_valid) begin
                    state_next = LO;
                end
            end
            LO: begin
                if (dst_t_ready) begin
                    if (upper_reg) begin
                        state_next = HI;
                    end else begin
                        state_next = src_t_valid ? LO : EMPTY;
                    end
                end
            end
            HI: begin
                if (dst_t_ready) begin
                    state_next = src_t_valid ? LO : EMPTY;
                end
            end
            default: state_next = EMPTY;
        endcase

        if (ready_int && src_t_valid) begin
            data_next  = src_t_data;
            last_next  = src_t_last;
            upper_next = |src_t_keep[7:4];
        end
    end

    // No source acceptance while reset is held
    assign src_t_ready = aresetn && ready_int;

    // Select the half of the held beat currently being presented
    assign half = (state_reg == HI) ? data_reg[63:32] : data_reg[31:0];

    for (genvar gi = 0; gi < 2; gi++) begin : g_px
        rgb565_expand u_expand (
            .pixel (half[RGB565_W*gi +: RGB565_W]),
            .xrgb  (px[gi])
        );
    end

    assign dst_t_data  = px;
    assign dst_t_valid = (state_reg != EMPTY);
    assign dst_t_last  = last_reg && ((state_reg == HI) || (state_reg == LO && !upper_reg));
    assign dst_t_keep  = '1;
    assign dst_t_strb  = '1;
    assign dst_t_dest  = '0;
    assign dst_t_id    = '0;
    assign dst_t_user  = '0;

endmodule

// File: tb/tb_rgb16to32.sv
// Directed-vector bench for rgb16to32: table of single beats, back-to-back
// streaming, random backpressure with a scoreboard, and reset in mid-beat.
module tb_rgb16to32;

    logic        aclk;
    logic        aresetn;
    logic        src_t_valid;
    logic        src_t_ready;
    logic [63:0] src_t_data;
    logic [7:0]  src_t_strb;
    logic [7:0]  src_t_keep;
    logic        src_t_last;
    logic [0:0]  src_t_dest;
    logic [0:0]  src_t_id;
    logic [0:0]  src_t_user;
    logic        dst_t_valid;
    logic        dst_t_ready;
    logic [63:0] dst_t_data;
    logic [7:0]  dst_t_strb;
    logic [7:0]  dst_t_keep;
    logic        dst_t_last;
    logic [0:0]  dst_t_dest;
    logic [0:0]  dst_t_id;
    logic [0:0]  dst_t_user;

    int n_vec = 0;
    int n_err = 0;

    rgb16to32 dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .src_t_valid (src_t_valid),
        .src_t_ready (src_t_ready),
        .src_t_data  (src_t_data),
        .src_t_strb  (src_t_strb),
        .src_t_keep  (src_t_keep),
        .src_t_last  (src_t_last),
        .src_t_dest  (src_t_dest),
        .src_t_id    (src_t_id),
        .src_t_user  (src_t_user),
        .dst_t_valid (dst_t_valid),
        .dst_t_ready (dst_t_ready),
        .dst_t_data  (dst_t_data),
        .dst_t_strb  (dst_t_strb),
        .dst_t_keep  (dst_t_keep),
        .dst_t_last  (dst_t_last),
        .dst_t_dest  (dst_t_dest),
        .dst_t_id    (dst_t_id),
        .dst_t_user  (dst_t_user)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [63:0] exp0;
        logic        exp_last0;
        logic        two;
        logic [63:0] exp1;
        logic        exp_last1;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    vec_t  vecs[7];
    beat_t sb_q[$];

    // Reference expansion of one RGB565 pixel
    function automatic logic [31:0] exp_px(input logic [15:0] p);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        r = p[15:11];
        g = p[10:5];
        b = p[4:0];
        return {8'h00, r, r[4:2], g, g[5:4], b, b[4:2]};
    endfunction

    task automatic cmp64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/extra expected handshake", nm);
    endtask

    // Present one source beat, wait (bounded) for its handshake, then drop valid
    task automatic drive_src(input logic [63:0] d, input logic [7:0] k, input logic l);
        logic got;
        got = 1'b0;
        @(negedge aclk);
        src_t_data  = d;
        src_t_keep  = k;
        src_t_last  = l;
        src_t_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            #1;
            if (src_t_ready) got = 1'b1;
            @(negedge aclk);
        end
        src_t_valid = 1'b0;
        if (!got) fail_now("src_handshake");
    endtask

    // Called at a negedge with dst_t_ready=1: the beat must be presented now
    task automatic expect_dst(input string nm, input logic [63:0] d, input logic l);
        #1;
        cmp64({nm, "_valid"}, {63'd0, dst_t_valid}, 64'd1);
        cmp64({nm, "_data"}, dst_t_data, d);
        cmp64({nm, "_last"}, {63'd0, dst_t_last}, {63'd0, l});
        @(negedge aclk);
    endtask

    initial begin
        logic [63:0] b2b_data [3];
        logic        hold;
        logic [63:0] held_data;
        logic        held_last;
        logic        accepted;
        int          sent;
        beat_t       bt;

        vecs[0] = '{64'h001F_07E0_F800_FFFF, 8'hFF, 1'b1, 64'h00FF0000_00FFFFFF, 1'b0, 1'b1, 64'h000000FF_0000FF00, 1'b1};
        vecs[1] = '{64'h8410_8410_8410_8410, 8'hFF, 1'b0, 64'h00848284_00848284, 1'b0, 1'b1, 64'h00848284_00848284, 1'b0};
        vecs[2] = '{64'h1234_5678_F800_001F, 8'h0F, 1'b1, 64'h00FF0000_000000FF, 1'b1, 1'b0, 64'h0,                 1'b0};
        vecs[3] = '{64'h0000_0000_0000_0000, 8'hFF, 1'b0, 64'h00000000_00000000, 1'b0, 1'b1, 64'h00000000_00000000, 1'b0};
        vecs[4] = '{64'hAAAA_5555_0841_FFE0, 8'hFF, 1'b1, 64'h00080808_00FFFF00, 1'b0, 1'b1, 64'h00AD5552_0052AAAD, 1'b1};
        vecs[5] = '{64'h0000_0000_001F_F800, 8'h0F, 1'b0, 64'h000000FF_00FF0000, 1'b0, 1'b0, 64'h0,                 1'b0};
        vecs[6] = '{64'h07E0_0000_0000_0000, 8'h10, 1'b1, 64'h00000000_00000000, 1'b0, 1'b1, 64'h0000FF00_00000000, 1'b1};

        aresetn     = 1'b0;
        src_t_valid = 1'b0;
        src_t_data  = '0;
        src_t_strb  = '1;
        src_t_keep  = '0;
        src_t_last  = 1'b0;
        src_t_dest  = '0;
        src_t_id    = '0;
        src_t_user  = '0;
        dst_t_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge aclk);
        #1;
        cmp64("rst_dst_valid", {63'd0, dst_t_valid}, 64'd0);
        cmp64("rst_dst_last",  {63'd0, dst_t_last},  64'd0);
        cmp64("rst_src_ready", {63'd0, src_t_ready}, 64'd0);
        cmp64("rst_dst_data",  dst_t_data, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        cmp64("rel_src_ready", {63'd0, src_t_ready}, 64'd1);
        cmp64("rel_dst_valid", {63'd0, dst_t_valid}, 64'd0);
        cmp64("side_keep_strb", {48'd0, dst_t_keep, dst_t_strb}, 64'h0000_0000_0000_FFFF);
        cmp64("side_dest_id_user", {61'd0, dst_t_dest, dst_t_id, dst_t_user}, 64'd0);

        // Table of single beats with free-running sink
        for (int i = 0; i < 7; i++) begin
            drive_src(vecs[i].data, vecs[i].keep, vecs[i].last);
            expect_dst($sformatf("v%0d_b0", i), vecs[i].exp0, vecs[i].exp_last0);
            if (vecs[i].two) expect_dst($sformatf("v%0d_b1", i), vecs[i].exp1, vecs[i].exp_last1);
            #1;
            cmp64($sformatf("v%0d_idle", i), {63'd0, dst_t_valid}, 64'd0);
        end

        // Back-to-back full beats: dst valid every cycle, src ready alternating
        b2b_data[0] = 64'h001F_07E0_F800_FFFF;
        b2b_data[1] = 64'hAAAA_5555_0841_FFE0;
        b2b_data[2] = 64'h8410_1234_FFFF_0000;
        src_t_keep  = 8'hFF;
        src_t_last  = 1'b0;
        for (int c = 0; c < 7; c++) begin
            logic [63:0] w;
            @(negedge aclk);
            src_t_valid = (c < 6);
            src_t_data  = b2b_data[c / 2 < 3 ? c / 2 : 2];
            #1;
            cmp64($sformatf("b2b_c%0d_src_ready", c), {63'd0, src_t_ready}, {63'd0, (c % 2) == 0});
            cmp64($sformatf("b2b_c%0d_dst_valid", c), {63'd0, dst_t_valid}, {63'd0, c > 0});
            if (c > 0) begin
                w = b2b_data[(c - 1) / 2];
                if (((c - 1) % 2) == 0) cmp64($sformatf("b2b_c%0d_data", c), dst_t_data, {exp_px(w[31:16]), exp_px(w[15:0])});
                else                    cmp64($sformatf("b2b_c%0d_data", c), dst_t_data, {exp_px(w[63:48]), exp_px(w[47:32])});
            end
        end
        @(negedge aclk);
        src_t_valid = 1'b0;
        #1;
        cmp64("b2b_idle", {63'd0, dst_t_valid}, 64'd0);

        // Random backpressure with scoreboard and hold-stability checks
        hold = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 3000 && (sent < 40 || sb_q.size() > 0 || src_t_valid); cyc++) begin
            @(negedge aclk);
            if (!src_t_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
                src_t_data  = {$urandom, $urandom};
                src_t_keep  = ($urandom_range(0, 2) != 0) ? 8'hFF : 8'h0F;
                src_t_last  = 1'($urandom_range(0, 1));
                src_t_valid = 1'b1;
            end
            dst_t_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                cmp64("rnd_hold_valid", {63'd0, dst_t_valid}, 64'd1);
                cmp64("rnd_hold_data", dst_t_data, held_data);
                cmp64("rnd_hold_last", {63'd0, dst_t_last}, {63'd0, held_last});
            end
            hold      = dst_t_valid && !dst_t_ready;
            held_data = dst_t_data;
            held_last = dst_t_last;
            if (dst_t_valid && dst_t_ready) begin
                if (sb_q.size() == 0) begin
                    fail_now("rnd_extra_beat");
                end else begin
                    bt = sb_q.pop_front();
                    cmp64("rnd_sb_data", dst_t_data, bt.data);
                    cmp64("rnd_sb_last", {63'd0, dst_t_last}, {63'd0, bt.last});
                end
            end
            accepted = src_t_valid && src_t_ready;
            if (accepted) begin
                if (src_t_keep[7:4] != 4'h0) begin
                    sb_q.push_back('{{exp_px(src_t_data[31:16]), exp_px(src_t_data[15:0])}, 1'b0});
                    sb_q.push_back('{{exp_px(src_t_data[63:48]), exp_px(src_t_data[47:32])}, src_t_last});
                end else begin
                    sb_q.push_back('{{exp_px(src_t_data[31:16]), exp_px(src_t_data[15:0])}, src_t_last});
                end
                sent++;
            end
            @(posedge aclk);
            #1;
            if (accepted) src_t_valid = 1'b0;
        end
        cmp64("rnd_all_sent", 64'(sent), 64'd40);
        cmp64("rnd_sb_drained", 64'(sb_q.size()), 64'd0);

        // Reset while presenting the upper half
        @(negedge aclk);
        dst_t_ready = 1'b1;
        src_t_valid = 1'b0;
        drive_src(64'h1111_2222_3333_4444, 8'hFF, 1'b1);
        #1;
        cmp64("rstmid_lo_data", dst_t_data, {exp_px(16'h3333), exp_px(16'h4444)});
        @(negedge aclk);
        dst_t_ready = 1'b0;
        #1;
        cmp64("rstmid_hi_data", dst_t_data, {exp_px(16'h1111), exp_px(16'h2222)});
        aresetn = 1'b0;
        #1;
        cmp64("rstmid_dst_valid", {63'd0, dst_t_valid}, 64'd0);
        cmp64("rstmid_dst_last",  {63'd0, dst_t_last},  64'd0);
        cmp64("rstmid_src_ready", {63'd0, src_t_ready}, 64'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        dst_t_ready = 1'b1;
        #1;
        cmp64("rstmid_rel_ready", {63'd0, src_t_ready}, 64'd1);
        cmp64("rstmid_rel_valid", {63'd0, dst_t_valid}, 64'd0);
        drive_src(64'h0000_0000_0000_FFFF, 8'hFF, 1'b0);
        expect_dst("rstmid_b0", 64'h00000000_00FFFFFF, 1'b0);
        expect_dst("rstmid_b1", 64'h00000000_00000000, 1'b0);
        #1;
        cmp64("rstmid_idle", {63'd0, dst_t_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
